// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared definitions for the 2-read/1-write register file.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default geometry (16 x 16)
//   word_t                        : one register word at the default width
//   addr_width()                  : address width for a given depth
// Configuration macro: REGFILE_BYPASS_EN (used by reg_file_2r1w).
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

  // A depth of 1 would give a zero-width address, so clamp to one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_file_word.sv
// reg_file_word
// One storage row of the register file.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset, clears the row
//   we   in  write enable
//   d    in  write data
//   q    out stored word
module reg_file_word
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (we) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w
// DEPTH x WIDTH architectural register file: one write port, two
// independent registered read ports with one-cycle latency and valid flags.
// Ports:
//   clk, rst                          clock / async active-high reset
//   WriteReg, WriteAddr, D            write port
//   ReadEnable1, ReadAddr1            read request, port 1
//   ReadEnable2, ReadAddr2            read request, port 2
//   Rdata1, Rvalid1, Rdata2, Rvalid2  registered read results
// Configuration macro:
//   REGFILE_BYPASS_EN defined   : a read hitting the address being written
//                                 in the same cycle returns the new data D.
//   REGFILE_BYPASS_EN undefined : such a read returns the old stored value.
// With ZERO_REG=1, register 0 always reads zero and ignores writes.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WriteReg,
  input  logic [AW-1:0]    WriteAddr,
  input  logic [WIDTH-1:0] D,
  input  logic             ReadEnable1,
  input  logic [AW-1:0]    ReadAddr1,
  input  logic             ReadEnable2,
  input  logic [AW-1:0]    ReadAddr2,
  output logic [WIDTH-1:0] Rdata1,
  output logic             Rvalid1,
  output logic [WIDTH-1:0] Rdata2,
  output logic             Rvalid2
);

  logic [DEPTH-1:0] row_we;
  logic [WIDTH-1:0] row_data [DEPTH];

  logic [WIDTH-1:0] rd1_word;
  logic [WIDTH-1:0] rd2_word;

  logic [WIDTH-1:0] rdata1_d, rdata1_q;
  logic [WIDTH-1:0] rdata2_d, rdata2_q;
  logic             rvalid1_d, rvalid1_q;
  logic             rvalid2_d, rvalid2_q;

  // One-hot write decode; a write to the hard-wired zero register is dropped
  // here so row 0 simply never loads.
  always_comb begin
    row_we = '0;
    if (WriteReg && !((ZERO_REG != 0) && (WriteAddr == '0))) begin
      row_we[WriteAddr] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_rows
    reg_file_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .we  (row_we[i]),
      .d   (D),
      .q   (row_data[i])
    );
  end

  // Read selection. The zero-register override is applied last so it also
  // wins over write-through forwarding.
  always_comb begin
    rd1_word = row_data[ReadAddr1];
    rd2_word = row_data[ReadAddr2];
`ifdef REGFILE_BYPASS_EN
    if (WriteReg && (ReadAddr1 == WriteAddr)) begin
      rd1_word = D;
    end
    if (WriteReg && (ReadAddr2 == WriteAddr)) begin
      rd2_word = D;
    end
`endif
    if ((ZERO_REG != 0) && (ReadAddr1 == '0)) begin
      rd1_word = '0;
    end
    if ((ZERO_REG != 0) && (ReadAddr2 == '0)) begin
      rd2_word = '0;
    end
  end

  // Data holds when a port is idle; only the valid flag drops.
  always_comb begin
    rdata1_d  = ReadEnable1 ? rd1_word : rdata1_q;
    rdata2_d  = ReadEnable2 ? rd2_word : rdata2_q;
    rvalid1_d = ReadEnable1;
    rvalid2_d = ReadEnable2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
    end else begin
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      rvalid1_q <= rvalid1_d;
      rvalid2_q <= rvalid2_d;
    end
  end

  assign Rdata1  = rdata1_q;
  assign Rdata2  = rdata2_q;
  assign Rvalid1 = rvalid1_q;
  assign Rvalid2 = rvalid2_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w
// Directed bench for reg_file_2r1w: a default 16x16 instance with ZERO_REG=1
// and a 32x8 instance with ZERO_REG=0 for the full-array sweep.
// Expected values for same-cycle read/write follow REGFILE_BYPASS_EN.
module tb_reg_file_2r1w;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Default-geometry instance
  logic        writeReg;
  logic [3:0]  writeAddr;
  logic [15:0] wdata;
  logic        readEnable1, readEnable2;
  logic [3:0]  readAddr1, readAddr2;
  logic [15:0] rdata1, rdata2;
  logic        rvalid1, rvalid2;

  // 32 x 8 sweep instance
  logic        bWriteReg;
  logic [4:0]  bWriteAddr;
  logic [7:0]  bWdata;
  logic        bReadEnable1, bReadEnable2;
  logic [4:0]  bReadAddr1, bReadAddr2;
  logic [7:0]  bRdata1, bRdata2;
  logic        bRvalid1, bRvalid2;

  int compareCount  = 0;
  int mismatchCount = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  reg_file_2r1w #(
    .WIDTH    (16),
    .DEPTH    (16),
    .ZERO_REG (1)
  ) dutA (
    .clk         (clk),
    .rst         (rst),
    .WriteReg    (writeReg),
    .WriteAddr   (writeAddr),
    .D           (wdata),
    .ReadEnable1 (readEnable1),
    .ReadAddr1   (readAddr1),
    .ReadEnable2 (readEnable2),
    .ReadAddr2   (readAddr2),
    .Rdata1      (rdata1),
    .Rvalid1     (rvalid1),
    .Rdata2      (rdata2),
    .Rvalid2     (rvalid2)
  );

  reg_file_2r1w #(
    .WIDTH    (8),
    .DEPTH    (32),
    .ZERO_REG (0)
  ) dutB (
    .clk         (clk),
    .rst         (rst),
    .WriteReg    (bWriteReg),
    .WriteAddr   (bWriteAddr),
    .D           (bWdata),
    .ReadEnable1 (bReadEnable1),
    .ReadAddr1   (bReadAddr1),
    .ReadEnable2 (bReadEnable2),
    .ReadAddr2   (bReadAddr2),
    .Rdata1      (bRdata1),
    .Rvalid1     (bRvalid1),
    .Rdata2      (bRdata2),
    .Rvalid2     (bRvalid2)
  );

  // Single comparison point: counts every check, reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are sampled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs on the default instance, then cross the edge
  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [15:0] d,
                               input logic re1, input logic [3:0] ra1,
                               input logic re2, input logic [3:0] ra2);
    writeReg    = we;
    writeAddr   = wa;
    wdata       = d;
    readEnable1 = re1;
    readAddr1   = ra1;
    readEnable2 = re2;
    readAddr2   = ra2;
    tick();
  endtask

  // Check both ports of the default instance in one call
  task automatic checkPorts(input string tag, input logic [15:0] d1, input logic v1,
                            input logic [15:0] d2, input logic v2);
    checkOutput({tag, "_rdata1"},  32'(rdata1),  32'(d1));
    checkOutput({tag, "_rvalid1"}, 32'(rvalid1), 32'(v1));
    checkOutput({tag, "_rdata2"},  32'(rdata2),  32'(d2));
    checkOutput({tag, "_rvalid2"}, 32'(rvalid2), 32'(v2));
  endtask

  initial begin
    logic [15:0] conflictExp;
    logic [15:0] bypassExp;

    rst = 1'b1;
    writeReg = 1'b0; writeAddr = '0; wdata = '0;
    readEnable1 = 1'b0; readAddr1 = '0; readEnable2 = 1'b0; readAddr2 = '0;
    bWriteReg = 1'b0; bWriteAddr = '0; bWdata = '0;
    bReadEnable1 = 1'b0; bReadAddr1 = '0; bReadEnable2 = 1'b0; bReadAddr2 = '0;

    #12;
    checkPorts("reset", 16'h0000, 1'b0, 16'h0000, 1'b0);
    tick();
    rst = 1'b0;

    // Write then read on the following cycle; port 2 reads the zero register
    applyStimulus(1'b1, 4'd3, 16'hA5A5, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 4'd0);
    checkPorts("wr_rd", 16'hA5A5, 1'b1, 16'h0000, 1'b1);

    // Idle ports hold data and drop valid
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0);
      checkPorts($sformatf("hold%0d", i), 16'hA5A5, 1'b0, 16'h0000, 1'b0);
    end

    // Zero register: write is dropped, reads stay zero even same-cycle
    applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0);
    checkPorts("zero_same", 16'h0000, 1'b1, 16'h0000, 1'b1);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 1'b0, 4'd0);
    checkPorts("zero_after", 16'h0000, 1'b1, 16'h0000, 1'b0);

    // Same-cycle read/write conflict on address 7
    conflictExp = BYPASS ? 16'h2222 : 16'h1111;
    applyStimulus(1'b1, 4'd7, 16'h1111, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'd7, 16'h2222, 1'b1, 4'd7, 1'b1, 4'd7);
    checkPorts("conflict", conflictExp, 1'b1, conflictExp, 1'b1);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b1, 4'd7);
    checkPorts("conflict_next", 16'h2222, 1'b1, 16'h2222, 1'b1);

    // Independent ports with unrelated writes in flight
    applyStimulus(1'b1, 4'd1, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'd2, 16'hBEEF, 1'b1, 4'd1, 1'b0, 4'd0);
    checkPorts("indep_a", 16'h1234, 1'b1, 16'h2222, 1'b0);
    applyStimulus(1'b1, 4'd9, 16'h0F0F, 1'b1, 4'd2, 1'b1, 4'd1);
    checkPorts("indep_b", 16'hBEEF, 1'b1, 16'h1234, 1'b1);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd9);
    checkPorts("indep_c", 16'hBEEF, 1'b0, 16'h0F0F, 1'b1);

    // Forwarding only on the port whose address matches the write
    bypassExp = BYPASS ? 16'h4444 : 16'h0000;
    applyStimulus(1'b1, 4'd4, 16'h4444, 1'b1, 4'd3, 1'b1, 4'd4);
    checkPorts("bypass_p2", 16'hA5A5, 1'b1, bypassExp, 1'b1);

    // Asynchronous reset mid-stream
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 4'd7);
    checkPorts("pre_reset", 16'hA5A5, 1'b1, 16'h2222, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkPorts("async_reset", 16'h0000, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 4'd5, 16'h5555, 1'b1, 4'd3, 1'b1, 4'd7);
    checkPorts("reset_held", 16'h0000, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 4'd3);
    checkPorts("post_reset", 16'h0000, 1'b1, 16'h0000, 1'b1);

    // Full sweep on the 32 x 8 instance
    for (int i = 0; i < 32; i++) begin
      bWriteReg  = 1'b1;
      bWriteAddr = 5'(i);
      bWdata     = 8'(i) ^ 8'h5A;
      tick();
    end
    bWriteReg = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bReadEnable1 = 1'b1;
      bReadAddr1   = 5'(i);
      bReadEnable2 = 1'b1;
      bReadAddr2   = 5'(31 - i);
      tick();
      checkOutput($sformatf("sweep_p1_%0d", i), 32'(bRdata1), 32'(8'(i) ^ 8'h5A));
      checkOutput($sformatf("sweep_p2_%0d", 31 - i), 32'(bRdata2), 32'(8'(31 - i) ^ 8'h5A));
      checkOutput($sformatf("sweep_v_%0d", i), 32'({bRvalid1, bRvalid2}), 32'd3);
    end
    bReadEnable1 = 1'b0;
    bReadEnable2 = 1'b0;
    tick();
    checkOutput("sweep_idle_v", 32'({bRvalid1, bRvalid2}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
